uart_tx: RTL and testbench

- UART 8N1 transmitter with a small write-side FIFO. Drives the `tx` pin.
- Counterpart to the UART receive path that feeds `rx`/`start_uart` program download.
- The CPU's MMIO layer pushes bytes; the block serialises them LSB-first at a fixed baud.
- Used for console output and for echoing and acknowledging downloaded program images back to the host.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_tx_if.sv | 39 +++
 rtl/uart_tx_fifo.sv | 74 +++++++
 rtl/uart_tx.sv | 181 ++++++++++++++++++
 tb/tb_uart_tx.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions, used by both the transmit and the receive paths.
//   tx_state_t            : transmitter FSM state encoding
//   DATA_BITS             : data bits per frame
//   DEFAULT_CLKS_PER_BIT  : 100 MHz / 115200 baud
// -----------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   localparam int DATA_BITS            = 8;
   localparam int DEFAULT_CLKS_PER_BIT = 868;

endpackage : uart_pkg

// File: rtl/uart_tx_if.sv
// -----------------------------------------------------------------------------
// uart_tx_if
// Write-side bus of the UART transmitter (CPU MMIO layer <-> uart_tx).
//   wr_en       : push request, accepted when full==0
//   wr_data     : byte to push
//   full        : FIFO holds FIFO_DEPTH bytes
//   fifo_count  : bytes queued, excluding the byte being shifted
//   overflow    : sticky, write attempted while full
// Modports: master = CPU side, slave = transmitter.
// -----------------------------------------------------------------------------
interface uart_tx_if
   import uart_pkg::*;
#(
   parameter int CNT_W = 5
) ();

   logic                 wr_en;
   logic [DATA_BITS-1:0] wr_data;
   logic                 full;
   logic [CNT_W-1:0]     fifo_count;
   logic                 overflow;

   modport master (
      output wr_en,
      output wr_data,
      input  full,
      input  fifo_count,
      input  overflow
   );

   modport slave (
      input  wr_en,
      input  wr_data,
      output full,
      output fifo_count,
      output overflow
   );

endinterface : uart_tx_if

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Synchronous byte FIFO for the transmitter; the head entry is presented
// combinationally on dout.
//   clk, rst : clock, synchronous active-high reset
//   push     : write din (ignored while full)
//   pop      : consume head entry (ignored while empty)
//   din/dout : write data / head entry
//   count    : number of stored entries
//   full     : count == FIFO_DEPTH
//   empty    : count == 0
// -----------------------------------------------------------------------------
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 push,
   input  logic                 pop,
   input  logic [DATA_BITS-1:0] din,
   output logic [DATA_BITS-1:0] dout,
   output logic [CNT_W-1:0]     count,
   output logic                 full,
   output logic                 empty
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr_q;
   logic [AW-1:0]        rd_ptr_q;
   logic [CNT_W-1:0]     count_q;
   logic                 push_ok;
   logic                 pop_ok;

   assign full    = (count_q == CNT_W'(FIFO_DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign dout    = mem_q[rd_ptr_q];
   // A write while full is dropped even if a pop frees a slot this cycle.
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   // NOTE: storage has no reset; pointers and count define validity, and
   // leaving the array unreset lets it map onto plain RAM cells.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

   // NOTE: all sequential state uses non-blocking assignment so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         // Pointers are log2(FIFO_DEPTH) wide, so they wrap naturally.
         if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule : uart_tx_fifo

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// UART transmitter (8N1, LSB first) fed by a small write FIFO.
//   clk       : system clock
//   fpga_rst  : synchronous active-high reset; aborts any frame in flight
//   wr        : uart_tx_if.slave write bus (wr_en, wr_data, full,
//               fifo_count, overflow)
//   busy      : FSM not IDLE
//   tx_done   : one-cycle pulse on the last cycle of each stop bit
//   tx        : registered serial line, idles high
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the data and stop bits (11-bit frame).
// -----------------------------------------------------------------------------
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int FIFO_DEPTH   = 16,
   parameter int CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
   input  logic     clk,
   input  logic     fpga_rst,
   uart_tx_if.slave wr,
   output logic     busy,
   output logic     tx_done,
   output logic     tx
);

   localparam int                BCW      = $clog2(CLKS_PER_BIT);
   localparam int                IW       = $clog2(DATA_BITS);
   localparam logic [BCW-1:0]    BIT_LAST = BCW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0]     IDX_LAST = IW'(DATA_BITS - 1);

   tx_state_t            state_q,   state_d;
   logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
   logic [IW-1:0]        bit_idx_q, bit_idx_d;
   logic [DATA_BITS-1:0] shift_q,   shift_d;
   logic                 tx_q,      tx_d;
   logic                 tx_done_q, tx_done_d;
   logic                 overflow_q;
   logic                 pop;
   logic                 fifo_empty;
   logic [DATA_BITS-1:0] fifo_dout;
   logic                 bit_last;

   uart_tx_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .CNT_W      (CNT_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (fpga_rst),
      .push  (wr.wr_en),
      .pop   (pop),
      .din   (wr.wr_data),
      .dout  (fifo_dout),
      .count (wr.fifo_count),
      .full  (wr.full),
      .empty (fifo_empty)
   );

   assign bit_last = (bit_cnt_q == BIT_LAST);

   // NOTE: every signal assigned here gets a default first, so no path
   // leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      tx_d      = tx_q;
      pop       = 1'b0;

      case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (!fifo_empty) begin
               pop       = 1'b1;
               shift_d   = fifo_dout;
               tx_d      = 1'b0;
               bit_cnt_d = '0;
               state_d   = START;
            end
         end

         START: begin
            if (bit_last) begin
               bit_cnt_d = '0;
               bit_idx_d = '0;
               tx_d      = shift_q[0];
               state_d   = DATA;
            end else begin
               bit_cnt_d = bit_cnt_q + BCW'(1);
            end
         end

         DATA: begin
            if (bit_last) begin
               bit_cnt_d = '0;
               if (bit_idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                  tx_d    = ^shift_q;
                  state_d = PARITY;
`else
                  tx_d    = 1'b1;
                  state_d = STOP;
`endif
               end else begin
                  // Shift register is indexed, not shifted, so it stays
                  // intact for the parity calculation.
                  bit_idx_d = bit_idx_q + IW'(1);
                  tx_d      = shift_q[bit_idx_q + IW'(1)];
               end
            end else begin
               bit_cnt_d = bit_cnt_q + BCW'(1);
            end
         end

`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (bit_last) begin
               bit_cnt_d = '0;
               tx_d      = 1'b1;
               state_d   = STOP;
            end else begin
               bit_cnt_d = bit_cnt_q + BCW'(1);
            end
         end
`endif

         STOP: begin
            if (bit_last) begin
               bit_cnt_d = '0;
               if (!fifo_empty) begin
                  // Chain straight into the next start bit: no idle gap.
                  pop     = 1'b1;
                  shift_d = fifo_dout;
                  tx_d    = 1'b0;
                  state_d = START;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               bit_cnt_d = bit_cnt_q + BCW'(1);
            end
         end

         default: state_d = IDLE;
      endcase

      // Registered so the pulse lands exactly on the final stop-bit cycle.
      tx_done_d = (state_d == STOP) && (bit_cnt_d == BIT_LAST);
   end

   always_ff @(posedge clk) begin
      if (fpga_rst) begin
         state_q    <= IDLE;
         bit_cnt_q  <= '0;
         bit_idx_q  <= '0;
         shift_q    <= '0;
         tx_q       <= 1'b1;
         tx_done_q  <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         tx_q      <= tx_d;
         tx_done_q <= tx_done_d;
         if (wr.wr_en && wr.full) begin
            overflow_q <= 1'b1;
         end
      end
   end

   assign busy        = (state_q != IDLE);
   assign tx_done     = tx_done_q;
   assign tx          = tx_q;
   assign wr.overflow = overflow_q;

endmodule : uart_tx

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
// Self-checking bench for uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Inputs are driven 1 time unit after the rising edge, outputs sampled on the
// falling edge. A passive line monitor decodes frames and compares them with
// a queue of bytes pushed when each accepted write is driven.
// -----------------------------------------------------------------------------
module tb_uart_tx;
   import uart_pkg::*;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;
`ifdef UART_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int FRAME = NBITS * CPB;

   logic clk;
   logic fpga_rst;
   logic busy;
   logic tx_done;
   logic tx;

   uart_tx_if #(.CNT_W(CW)) wr_if ();

   uart_tx #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH),
      .CNT_W        (CW)
   ) dut (
      .clk      (clk),
      .fpga_rst (fpga_rst),
      .wr       (wr_if.slave),
      .busy     (busy),
      .tx_done  (tx_done),
      .tx       (tx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   logic [7:0] exp_q [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Vector table: byte, its bits in transmission order, expected parity.
   typedef struct {
      logic [7:0] data;
      logic [0:7] serial;
      logic       par;
   } vec_t;

   vec_t vecs [5];

   // ---------------- line monitor / scoreboard ----------------
   logic       mon_active = 1'b0;
   int         mon_t;
   int         mon_k;
   logic [7:0] mon_byte;
   logic       mon_par;

   always @(negedge clk) begin
      if (fpga_rst === 1'b1) begin
         mon_active = 1'b0;
      end else if (!mon_active) begin
         if (tx === 1'b0) begin
            mon_active = 1'b1;
            mon_t      = 0;
            mon_byte   = '0;
            mon_par    = 1'b0;
         end
      end else begin
         mon_t++;
         if (mon_t % CPB == CPB / 2) begin
            mon_k = mon_t / CPB;
            if (mon_k == 0) begin
               check("mon_start_bit", tx, 1'b0);
            end else if (mon_k <= 8) begin
               mon_byte[mon_k-1] = tx;
            end else if (mon_k < NBITS - 1) begin
               mon_par = tx;
            end else begin
               check("mon_stop_bit", tx, 1'b1);
`ifdef UART_TX_PARITY_EN
               check("mon_parity", mon_par, ^mon_byte);
`endif
               check("sb_has_entry", exp_q.size() > 0, 1'b1);
               if (exp_q.size() > 0) check("sb_byte", mon_byte, exp_q.pop_front());
               mon_active = 1'b0;
            end
         end
      end
   end

   // ---------------- helpers ----------------
   function automatic logic exp_level(input vec_t v, input int m);
      int k;
      if (m > FRAME || m < 1) return 1'b1;
      k = (m - 1) / CPB;
      if (k == 0) return 1'b0;
      if (k <= 8) return v.serial[k-1];
      if (k < NBITS - 1) return v.par;
      return 1'b1;
   endfunction

   // Push one byte; returns 1 unit after the accepting edge with wr_en low.
   task automatic push_byte(input logic [7:0] d);
      @(posedge clk);
      #1;
      wr_if.wr_en   = 1'b1;
      wr_if.wr_data = d;
      exp_q.push_back(d);
      @(posedge clk);
      #1;
      wr_if.wr_en = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (!busy) break;
      end
      check("idle_within_budget", busy, 1'b0);
   endtask

   // Single frame checked cycle by cycle: tx level, tx_done, busy.
   task automatic run_vector(input vec_t v);
      push_byte(v.data);
      @(negedge clk);
      check("push_count", wr_if.fifo_count, 1);
      check("push_busy", busy, 1'b0);
      check("push_tx_idle", tx, 1'b1);
      for (int m = 1; m <= FRAME + 1; m++) begin
         @(negedge clk);
         check($sformatf("tx_%02h_m%0d", v.data, m), tx, exp_level(v, m));
         check($sformatf("done_%02h_m%0d", v.data, m), tx_done, (m == FRAME));
         check($sformatf("busy_%02h_m%0d", v.data, m), busy, (m <= FRAME));
      end
      check("post_frame_count", wr_if.fifo_count, 0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{data: 8'hA5, serial: 8'b10100101, par: 1'b0};
      vecs[1] = '{data: 8'h07, serial: 8'b11100000, par: 1'b1};
      vecs[2] = '{data: 8'h80, serial: 8'b00000001, par: 1'b1};
      vecs[3] = '{data: 8'h00, serial: 8'b00000000, par: 1'b0};
      vecs[4] = '{data: 8'hFF, serial: 8'b11111111, par: 1'b0};

      wr_if.wr_en   = 1'b0;
      wr_if.wr_data = '0;
      fpga_rst      = 1'b1;

      // ---- reset idle ----
      repeat (5) @(posedge clk);
      #1 fpga_rst = 1'b0;
      @(negedge clk);
      check("rst_tx", tx, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_done", tx_done, 1'b0);
      check("rst_count", wr_if.fifo_count, 0);
      check("rst_full", wr_if.full, 1'b0);
      check("rst_overflow", wr_if.overflow, 1'b0);

      // ---- table-driven single frames ----
      foreach (vecs[i]) begin
         run_vector(vecs[i]);
         repeat (3) @(negedge clk);
      end

      // ---- back-to-back 55, 0F ----
      @(posedge clk);
      #1;
      wr_if.wr_en   = 1'b1;
      wr_if.wr_data = 8'h55;
      exp_q.push_back(8'h55);
      @(posedge clk);
      #1;
      wr_if.wr_data = 8'h0F;
      exp_q.push_back(8'h0F);
      @(posedge clk);
      #1;
      wr_if.wr_en = 1'b0;
      @(negedge clk);
      check("b2b_busy_start", busy, 1'b1);
      check("b2b_count", wr_if.fifo_count, 1);
      for (int m = 2; m <= 2 * FRAME + 1; m++) begin
         @(negedge clk);
         check($sformatf("b2b_busy_m%0d", m), busy, (m <= 2 * FRAME));
         check($sformatf("b2b_done_m%0d", m), tx_done, (m == FRAME || m == 2 * FRAME));
         if (m == FRAME)     check("b2b_stop1", tx, 1'b1);
         if (m == FRAME + 1) check("b2b_start2_no_gap", tx, 1'b0);
         if (m == 2 * FRAME) check("b2b_stop2", tx, 1'b1);
      end
      check("b2b_count_end", wr_if.fifo_count, 0);

      // ---- full / overflow ----
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1;
      wr_if.wr_en   = 1'b1;
      wr_if.wr_data = 8'h01;
      exp_q.push_back(8'h01);
      for (int j = 0; j < 5; j++) begin
         @(posedge clk);
         #1;
         wr_if.wr_data = 8'(j + 2);
         if (j < 4) exp_q.push_back(8'(j + 2));
         if (j == 4) begin
            @(negedge clk);
            check("ovf_full_before", wr_if.full, 1'b1);
            check("ovf_count_before", wr_if.fifo_count, DEPTH);
            check("ovf_flag_before", wr_if.overflow, 1'b0);
         end
      end
      @(posedge clk);
      #1;
      wr_if.wr_en = 1'b0;
      @(negedge clk);
      check("ovf_full_after", wr_if.full, 1'b1);
      check("ovf_count_after", wr_if.fifo_count, DEPTH);
      check("ovf_flag_after", wr_if.overflow, 1'b1);
      repeat (FRAME - 4) @(posedge clk);
      @(negedge clk);
      check("ovf_pop_count", wr_if.fifo_count, DEPTH - 1);
      check("ovf_pop_full", wr_if.full, 1'b0);
      check("ovf_pop_start", tx, 1'b0);
      wait_idle(5 * FRAME + 20);
      check("ovf_sticky", wr_if.overflow, 1'b1);
      check("ovf_sb_drained", exp_q.size(), 0);

      // ---- reset mid-frame (during data bit 3), with a byte queued ----
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1;
      wr_if.wr_en   = 1'b1;
      wr_if.wr_data = 8'hFF;
      @(posedge clk);
      #1;
      wr_if.wr_data = 8'h11;
      @(posedge clk);
      #1;
      wr_if.wr_en = 1'b0;
      repeat (17) @(posedge clk);
      @(negedge clk);
      check("mid_busy_before", busy, 1'b1);
      check("mid_count_before", wr_if.fifo_count, 1);
      check("mid_bit3", tx, 1'b1);
      @(posedge clk);
      #1 fpga_rst = 1'b1;
      exp_q.delete();
      @(posedge clk);
      #1 fpga_rst = 1'b0;
      @(negedge clk);
      check("mid_tx", tx, 1'b1);
      check("mid_busy", busy, 1'b0);
      check("mid_count", wr_if.fifo_count, 0);
      check("mid_done", tx_done, 1'b0);
      check("mid_overflow_cleared", wr_if.overflow, 1'b0);
      for (int m = 0; m < FRAME + 10; m++) begin
         @(negedge clk);
         check($sformatf("mid_quiet_done_%0d", m), tx_done, 1'b0);
         check($sformatf("mid_quiet_tx_%0d", m), tx, 1'b1);
      end
      run_vector('{data: 8'h3C, serial: 8'b00111100, par: 1'b0});

      wait_idle(FRAME);
      repeat (4) @(negedge clk);
      check("sb_final_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_uart_tx
